// File: rtl/apb_to_ahb_bridge.sv
// -----------------------------------------------------------------------------
// apb_to_ahb_bridge
//
// APB3 completer that turns every APB access into exactly one single-beat
// AHB-Lite transfer, acting as the AHB manager. The APB access is stretched
// (PREADY low) until the AHB data phase has finished. Only one transfer is in
// flight at a time; there is no address/data pipelining on the AHB side.
//
// Ports
//   HCLK, HRESET         single clock, asynchronous active-high reset
//   PSEL, PENABLE        APB select / access phase
//   PADDR, PWRITE        APB address / direction (1 = write)
//   PWDATA               APB write data
//   PRDATA               APB read data (0 outside the completion cycle)
//   PREADY, PSLVERR      APB completion pulse / error, valid with PREADY
//   HADDR, HTRANS        AHB address / transfer type (IDLE or NONSEQ only)
//   HWRITE               AHB direction
//   HSIZE, HBURST        tied to word / SINGLE
//   HWDATA               AHB write data
//   HRDATA               AHB read data
//   HREADY, HRESP        AHB ready / response (1 = ERROR)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for an APB setup phase; AHB bus idle
// ADDR  | AHB address phase, NONSEQ driven until HREADY accepts it
// DATA  | AHB data phase; wait states and two-cycle ERROR handled here
// RESP  | one-cycle APB completion: PREADY=1, PSLVERR/PRDATA valid
// -----------------------------------------------------------------------------
module apb_to_ahb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic setup;
  assign setup = PSEL && !PENABLE;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. PSEL dropping mid-transfer is deliberately not looked
  // at outside IDLE: the AHB transfer and the PREADY pulse always complete.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (setup)  state_nxt = ADDR;
      ADDR: if (HREADY) state_nxt = DATA;
      DATA: if (HREADY) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latches, read-data capture and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            // Word transfers only: the byte offset is dropped.
            addr_q  <= {PADDR[ADDR_WIDTH-1:2], 2'b00};
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            err_q   <= 1'b0;
          end
        end
        DATA: begin
          if (HRESP) begin
            // Covers both cycles of the two-cycle ERROR response.
            err_q <= 1'b1;
          end else if (HREADY) begin
            err_q <= 1'b0;
            if (!write_q) rdata_q <= HRDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from state and registered latches, never from the
  // APB inputs directly.
  // ---------------------------------------------------------------------------
  assign HTRANS  = (state == ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR   = addr_q;
  assign HWRITE  = write_q;
  assign HWDATA  = wdata_q;
  assign HSIZE   = 3'b010;
  assign HBURST  = 3'b000;

  assign PREADY  = (state == RESP);
  assign PSLVERR = (state == RESP) && err_q;
  // Erroring reads and all writes return zero.
  assign PRDATA  = ((state == RESP) && !write_q && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
module tb_apb_to_ahb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  int vectors = 0;
  int miscompares = 0;

  apb_to_ahb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One APB access against a directed AHB slave. Entered and left at #1 after
  // a rising edge with the bridge in IDLE; leaves one cycle after RESP, so a
  // following call issues its setup back-to-back.
  task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input int waits, input bit err,
                      input logic [31:0] slave_rd, input logic [31:0] exp_haddr,
                      input logic [31:0] exp_prdata, input logic exp_err);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = wd;
    HREADY = 1'b1; HRESP = 1'b0;
    tick();
    chk({tag, ":htrans_addr"}, {30'd0, HTRANS}, 32'h2);
    chk({tag, ":haddr"}, HADDR, exp_haddr);
    chk({tag, ":hwrite"}, {31'd0, HWRITE}, {31'd0, w});
    chk({tag, ":pready_addr"}, {31'd0, PREADY}, 32'd0);
    PENABLE = 1'b1;
    tick();
    chk({tag, ":htrans_data"}, {30'd0, HTRANS}, 32'h0);
    chk({tag, ":hwdata"}, HWDATA, wd);
    for (int i = 0; i < waits; i++) begin
      HREADY = 1'b0; HRESP = 1'b0;
      tick();
      chk({tag, ":htrans_wait"}, {30'd0, HTRANS}, 32'h0);
      chk({tag, ":pready_wait"}, {31'd0, PREADY}, 32'd0);
      chk({tag, ":haddr_wait"}, HADDR, exp_haddr);
      chk({tag, ":hwdata_wait"}, HWDATA, wd);
    end
    if (err) begin
      HREADY = 1'b0; HRESP = 1'b1;
      tick();
      chk({tag, ":pready_err1"}, {31'd0, PREADY}, 32'd0);
      HREADY = 1'b1; HRESP = 1'b1; HRDATA = slave_rd;
    end else begin
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = slave_rd;
    end
    tick();
    chk({tag, ":pready"}, {31'd0, PREADY}, 32'd1);
    chk({tag, ":pslverr"}, {31'd0, PSLVERR}, {31'd0, exp_err});
    chk({tag, ":prdata"}, PRDATA, exp_prdata);
    chk({tag, ":htrans_resp"}, {30'd0, HTRANS}, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h5A5A_A5A5;
    tick();
    chk({tag, ":pready_after"}, {31'd0, PREADY}, 32'd0);
    chk({tag, ":prdata_after"}, PRDATA, 32'd0);
    chk({tag, ":pslverr_after"}, {31'd0, PSLVERR}, 32'd0);
  endtask

  initial begin
    HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0;
    PWDATA = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    tick(); tick();
    chk("rst:htrans", {30'd0, HTRANS}, 32'h0);
    chk("rst:pready", {31'd0, PREADY}, 32'd0);
    chk("rst:pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("rst:prdata", PRDATA, 32'd0);
    chk("rst:haddr", HADDR, 32'd0);
    chk("rst:hwdata", HWDATA, 32'd0);
    chk("rst:hwrite", {31'd0, HWRITE}, 32'd0);
    chk("rst:hsize", {29'd0, HSIZE}, 32'h2);
    chk("rst:hburst", {29'd0, HBURST}, 32'h0);
    HRESET = 1'b0;
    tick();

    // single write and read, zero-wait slave
    xfer("wr4", 32'h4, 1'b1, 32'hBEEF_BEEF, 0, 0, 32'h0, 32'h4, 32'h0, 1'b0);
    xfer("rd4", 32'h4, 1'b0, 32'h0, 0, 0, 32'hBEEF_BEEF, 32'h4, 32'hBEEF_BEEF, 1'b0);

    // three data-phase wait states on a read
    xfer("rdC", 32'hC, 1'b0, 32'h1234_5678, 3, 0, 32'hCAFE_F00D, 32'hC, 32'hCAFE_F00D, 1'b0);

    // error responses, then a clean transfer
    xfer("wr40err", 32'h40, 1'b1, 32'h0000_0040, 0, 1, 32'h0, 32'h40, 32'h0, 1'b1);
    xfer("rd44err", 32'h44, 1'b0, 32'h0, 1, 1, 32'hDEAD_DEAD, 32'h44, 32'h0, 1'b1);
    xfer("rd4ok", 32'h4, 1'b0, 32'h0, 0, 0, 32'h0BAD_CAFE, 32'h4, 32'h0BAD_CAFE, 1'b0);

    // back-to-back writes, last one unaligned, then readback
    xfer("b2b0", 32'h20, 1'b1, 32'h1000_0000, 0, 0, 32'h0, 32'h20, 32'h0, 1'b0);
    xfer("b2b1", 32'h24, 1'b1, 32'h1000_0001, 0, 0, 32'h0, 32'h24, 32'h0, 1'b0);
    xfer("b2b2", 32'h28, 1'b1, 32'h1000_0002, 0, 0, 32'h0, 32'h28, 32'h0, 1'b0);
    xfer("b2b3", 32'h2B, 1'b1, 32'h1000_0003, 0, 0, 32'h0, 32'h28, 32'h0, 1'b0);
    xfer("rb20", 32'h20, 1'b0, 32'h0, 0, 0, 32'h1000_0000, 32'h20, 32'h1000_0000, 1'b0);
    xfer("rb24", 32'h24, 1'b0, 32'h0, 0, 0, 32'h1000_0001, 32'h24, 32'h1000_0001, 1'b0);
    xfer("rb28", 32'h28, 1'b0, 32'h0, 0, 0, 32'h1000_0003, 32'h28, 32'h1000_0003, 1'b0);

    // reset asserted during the data phase of a write
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h60; PWRITE = 1'b1; PWDATA = 32'h7777_7777;
    HREADY = 1'b1; HRESP = 1'b0;
    tick();
    chk("rstmid:htrans_addr", {30'd0, HTRANS}, 32'h2);
    PENABLE = 1'b1;
    tick();
    HREADY = 1'b0;
    chk("rstmid:hwdata", HWDATA, 32'h7777_7777);
    #2 HRESET = 1'b1;
    #1;
    chk("rstmid:htrans", {30'd0, HTRANS}, 32'h0);
    chk("rstmid:pready", {31'd0, PREADY}, 32'd0);
    chk("rstmid:haddr", HADDR, 32'd0);
    chk("rstmid:hwdata0", HWDATA, 32'd0);
    chk("rstmid:hwrite", {31'd0, HWRITE}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
    tick();
    HRESET = 1'b0;
    tick();
    chk("rstmid:idle", {30'd0, HTRANS}, 32'h0);
    xfer("rd50", 32'h50, 1'b0, 32'h0, 0, 0, 32'h5050_5050, 32'h50, 32'h5050_5050, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
